seq_det: RTL and testbench

SEQ_DET -- requirements
Module: seq_det

---
 rtl/seq_det.sv | 164 ++++++++++++++++
 tb/tb_seq_det.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det.sv
// seq_det: streaming pattern detector with a runtime-loadable pattern of up to LEN symbols.
// The all-ones symbol (ESC) aborts the sequence in progress. Every accepted symbol is
// checked against every possible prefix length in parallel, using a short window of
// recent symbols.
// Optional feature: define SEQ_DET_OVERLAP_EN to keep the history after a match, which
// allows overlapping matches. When it is not defined, a match restarts detection.

module seq_det #(
  parameter int unsigned SYM_W = 2,
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned LW   = $clog2(LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sym_valid,
  input  logic [SYM_W-1:0]     sym,
  input  logic                 pat_load,
  input  logic [LEN*SYM_W-1:0] pat_data,
  input  logic [LW-1:0]        pat_len,
  output logic                 match,
  output logic [LW-1:0]        state,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 load_err
);

  typedef logic [SYM_W-1:0] sym_t;

  localparam logic [LW-1:0] LenMax = LW'(LEN);
  localparam sym_t          Esc    = '1;

  // Registered state
  logic [LEN*SYM_W-1:0] pat_q, pat_d;
  logic [LW-1:0]        act_len_q, act_len_d;
  logic [LW-1:0]        state_q, state_d;
  logic [LW-1:0]        hist_len_q, hist_len_d;
  sym_t                 hist_q [LEN-1];
  sym_t                 hist_d [LEN-1];
  logic                 match_q, match_d;
  logic                 load_err_q, load_err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Combinational helpers
  sym_t          pat_sym [LEN];
  sym_t          win [LEN];      // win[0] is the incoming symbol, win[i] is i symbols older
  logic [LW-1:0] avail;          // history length once the incoming symbol is counted
  logic [LEN-1:0] hit;           // hit[k-1]: last k symbols equal pattern symbols 0..k-1
  logic [LW-1:0] k_best;
  logic          full;
  logic          len_ok;
  logic          is_esc;
`ifdef SEQ_DET_OVERLAP_EN
  logic [LW-1:0] k_prop;         // longest proper prefix that is also a suffix
`endif

  // State register: pattern, active length, prefix state, history and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q      <= '0;
      act_len_q  <= LenMax;
      state_q    <= '0;
      hist_len_q <= '0;
      hist_q     <= '{default: '0};
      match_q    <= 1'b0;
      load_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pat_q      <= pat_d;
      act_len_q  <= act_len_d;
      state_q    <= state_d;
      hist_len_q <= hist_len_d;
      hist_q     <= hist_d;
      match_q    <= match_d;
      load_err_q <= load_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Window of the most recent symbols and per-length prefix comparison
  always_comb begin
    for (int i = 0; i < LEN; i++) begin
      pat_sym[i] = pat_q[i*SYM_W +: SYM_W];
    end
    win[0] = sym;
    for (int i = 1; i < LEN; i++) begin
      win[i] = hist_q[i-1];
    end
    avail = (hist_len_q == LenMax) ? LenMax : hist_len_q + LW'(1);
    hit   = '0;
    for (int k = 1; k <= LEN; k++) begin
      hit[k-1] = (LW'(k) <= avail) && (LW'(k) <= act_len_q);
      // Oldest symbol of the window lines up with pattern symbol 0
      for (int i = 0; i < k; i++) begin
        if (win[i] != pat_sym[k-1-i]) hit[k-1] = 1'b0;
      end
    end
    k_best = '0;
`ifdef SEQ_DET_OVERLAP_EN
    k_prop = '0;
`endif
    for (int k = 1; k <= LEN; k++) begin
      if (hit[k-1]) k_best = LW'(k);
`ifdef SEQ_DET_OVERLAP_EN
      if (hit[k-1] && (LW'(k) < act_len_q)) k_prop = LW'(k);
`endif
    end
    full   = (k_best == act_len_q);
    len_ok = (pat_len != '0) && (pat_len <= LenMax);
    is_esc = (sym == Esc);
  end

  // Next-state: a load beats a symbol, ESC aborts, and a full-length hit is a match
  always_comb begin
    pat_d      = pat_q;
    act_len_d  = act_len_q;
    state_d    = state_q;
    hist_len_d = hist_len_q;
    hist_d     = hist_q;
    match_d    = 1'b0;
    load_err_d = 1'b0;
    cnt_d      = cnt_q;
    if (pat_load) begin
      if (len_ok) begin
        pat_d      = pat_data;
        act_len_d  = pat_len;
        state_d    = '0;
        hist_len_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (sym_valid) begin
      if (is_esc) begin
        state_d    = '0;
        hist_len_d = '0;
      end else begin
        for (int i = 0; i < LEN - 1; i++) begin
          hist_d[i] = win[i];
        end
        hist_len_d = avail;
        if (full) begin
          match_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_DET_OVERLAP_EN
          state_d    = k_prop;
`else
          state_d    = '0;
          hist_len_d = '0;
`endif
        end else begin
          state_d = k_best;
        end
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    match     = match_q;
    state     = state_q;
    match_cnt = cnt_q;
    load_err  = load_err_q;
  end

endmodule

// File: tb/tb_seq_det.sv
// tb_seq_det: directed scenarios plus random traffic for seq_det, every output compared
// against a queue-based reference model after each clock edge.

module tb_seq_det;

  localparam int unsigned SYM_W = 2;
  localparam int unsigned LEN   = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LW    = $clog2(LEN + 1);
  localparam int          ESC   = (1 << SYM_W) - 1;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sym_valid;
  logic [SYM_W-1:0]     sym;
  logic                 pat_load;
  logic [LEN*SYM_W-1:0] pat_data;
  logic [LW-1:0]        pat_len;
  logic                 match;
  logic [LW-1:0]        state;
  logic [CNT_W-1:0]     match_cnt;
  logic                 load_err;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: accepted symbols since the last clear, newest at the back
  int m_pat [LEN];
  int m_len;
  int hq [$];
  int m_state;
  int m_cnt;
  int m_match;
  int m_lerr;

  seq_det #(
    .SYM_W(SYM_W),
    .LEN  (LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sym_valid(sym_valid),
    .sym      (sym),
    .pat_load (pat_load),
    .pat_data (pat_data),
    .pat_len  (pat_len),
    .match    (match),
    .state    (state),
    .match_cnt(match_cnt),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Largest k <= limit such that the last k history symbols equal pattern symbols 0..k-1
  function automatic int longest(input int limit);
    int ok;
    for (int k = limit; k >= 1; k--) begin
      if (k <= hq.size()) begin
        ok = 1;
        for (int j = 0; j < k; j++) begin
          if (hq[hq.size() - k + j] != m_pat[j]) ok = 0;
        end
        if (ok != 0) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    hq.delete();
    for (int k = 0; k < LEN; k++) m_pat[k] = 0;
    m_len   = LEN;
    m_state = 0;
    m_cnt   = 0;
    m_match = 0;
    m_lerr  = 0;
  endtask

  task automatic model_step(input int v, input int s, input int ld,
                            input logic [LEN*SYM_W-1:0] data, input int len);
    int k;
    m_match = 0;
    m_lerr  = 0;
    if (ld != 0) begin
      if (len >= 1 && len <= LEN) begin
        for (int i = 0; i < LEN; i++) m_pat[i] = int'(data[i*SYM_W +: SYM_W]);
        m_len   = len;
        hq.delete();
        m_state = 0;
      end else begin
        m_lerr = 1;
      end
    end else if (v != 0) begin
      if (s == ESC) begin
        hq.delete();
        m_state = 0;
      end else begin
        hq.push_back(s);
        if (hq.size() > LEN) void'(hq.pop_front());
        k = longest(m_len);
        if (k == m_len) begin
          m_match = 1;
          if (m_cnt < CMAX) m_cnt++;
`ifdef SEQ_DET_OVERLAP_EN
          m_state = longest(m_len - 1);
`else
          hq.delete();
          m_state = 0;
`endif
        end else begin
          m_state = k;
        end
      end
    end
  endtask

  // One clock: apply inputs, advance the model, compare every output after the edge
  task automatic cycle(input int v, input int s, input int ld,
                       input logic [LEN*SYM_W-1:0] data, input int len);
    sym_valid = (v != 0);
    sym       = SYM_W'(s);
    pat_load  = (ld != 0);
    pat_data  = data;
    pat_len   = LW'(len);
    @(posedge clk);
    #1;
    model_step(v, s, ld, data, len);
    check("match", 32'(match), 32'(m_match));
    check("state", 32'(state), 32'(m_state));
    check("cnt", 32'(match_cnt), 32'(m_cnt));
    check("load_err", 32'(load_err), 32'(m_lerr));
    sym_valid = 1'b0;
    pat_load  = 1'b0;
  endtask

  task automatic send(input int s);
    cycle(1, s, 0, '0, 0);
  endtask

  task automatic load(input logic [LEN*SYM_W-1:0] data, input int len);
    cycle(0, 0, 1, data, len);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_match"}, 32'(match), 0);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_cnt"}, 32'(match_cnt), 0);
    check({tag, "_lerr"}, 32'(load_err), 0);
  endtask

  int seq031 [6] = '{0, 1, 0, 1, 0, 1};
  int seq032 [7] = '{0, 1, 0, 3, 1, 0, 1};
  int st032  [7] = '{1, 2, 3, 0, 0, 1, 2};
  int seq033 [5] = '{0, 0, 1, 0, 1};
  int st033  [4] = '{1, 1, 2, 3};
  int seq_p  [4] = '{0, 1, 0, 1};

  initial begin
    int base;
    int guard;
    int r;
    int nmatch;
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym       = '0;
    pat_load  = 1'b0;
    pat_data  = '0;
    pat_len   = '0;
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;

    load(8'h44, 4);

    // Repeating 0,1 stream: overlap yields two matches, otherwise one
    send(ESC);
    base   = m_cnt;
    nmatch = 0;
    for (int i = 0; i < 6; i++) begin
      send(seq031[i]);
      nmatch += int'(match);
    end
`ifdef SEQ_DET_OVERLAP_EN
    check("ovl_pulses", 32'(nmatch), 2);
    check("ovl_cnt", 32'(match_cnt) - 32'(base), 2);
`else
    check("ovl_pulses", 32'(nmatch), 1);
    check("ovl_cnt", 32'(match_cnt) - 32'(base), 1);
`endif

    // ESC in the middle aborts the partial match
    send(ESC);
    for (int i = 0; i < 7; i++) begin
      send(seq032[i]);
      check("esc_state", 32'(state), 32'(st032[i]));
      check("esc_nomatch", 32'(match), 0);
    end

    // Fallback after a mismatch keeps the repeated leading 0
    send(ESC);
    for (int i = 0; i < 5; i++) begin
      send(seq033[i]);
      if (i < 4) check("fb_state", 32'(state), 32'(st033[i]));
      check("fb_match", 32'(match), (i == 4) ? 1 : 0);
    end

    // Rejected loads leave the pattern alone
    load(8'h00, 0);
    check("lerr_len0", 32'(load_err), 1);
    load(8'hFF, 5);
    check("lerr_len5", 32'(load_err), 1);
    send(ESC);
    for (int i = 0; i < 4; i++) send(seq_p[i]);
    check("after_bad_load", 32'(match), 1);

    // Load beats a simultaneous symbol
    send(ESC);
    for (int i = 0; i < 3; i++) send(seq_p[i]);
    cycle(1, 1, 1, 8'h44, 4);
    check("load_prio", 32'(match), 0);

    // Counter saturation
    send(ESC);
    guard = 0;
    while (m_cnt < CMAX - 1 && guard < 5000) begin
      send(seq_p[guard % 4]);
      guard++;
    end
    check("preload_bound", 32'(m_cnt), 32'(CMAX - 1));
    for (int n = 0; n < 3; n++) begin
      send(ESC);
      for (int i = 0; i < 4; i++) send(seq_p[i]);
      check("sat_match", 32'(match), 1);
      check("sat_cnt", 32'(match_cnt), 255);
    end

    // Random traffic, including random loads
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        load(LEN*SYM_W'($urandom), $urandom_range(0, 6));
      end else if (r < 20) begin
        cycle(0, $urandom_range(0, 3), 0, '0, 0);
      end else begin
        send(($urandom_range(0, 9) == 0) ? ESC : $urandom_range(0, 2));
      end
    end

    // Reset in the middle of a sequence
    load(8'h44, 4);
    send(ESC);
    for (int i = 0; i < 3; i++) send(seq_p[i]);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("mid_reset");
    #2;
    rst_n = 1'b1;
    send(1);
    check("post_reset_state", 32'(state), 0);
    check("post_reset_match", 32'(match), 0);

    load(8'h44, 4);
    for (int n = 0; n < 300; n++) begin
      send(($urandom_range(0, 9) == 0) ? ESC : $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
